// File: rtl/seg_display_mux.sv
// Paged, time-multiplexed hex display of a wide value with HALT blink and an ERROR flag view.
// Build option: define SEG_PAGE_DP_EN to light the dp of the digit whose index equals the page.
module seg_display_mux #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned PAGE_FRAMES  = 256,
  parameter int unsigned BLINK_FRAMES = 128,
  localparam int unsigned NUM_PAGES   = (DATA_WIDTH + 4 * NUM_DIGITS - 1) / (4 * NUM_DIGITS),
  localparam int unsigned PAGE_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [2:0]            nstate_i,
  input  logic [3:0]            interrupts_i,
  output logic [7:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [PAGE_W-1:0]     page_o
);

  localparam int unsigned PRE_W    = $clog2(SCAN_DIV);
  localparam int unsigned DIG_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FRM_W    = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
  localparam int unsigned BLK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned NIB_TOT  = NUM_PAGES * NUM_DIGITS;
  localparam int unsigned NIB_W    = $clog2(NIB_TOT) + 1;
  localparam int unsigned PAD_W    = NIB_TOT * 4;
  localparam int unsigned NUM_NIBS = DATA_WIDTH / 4;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_HALT   = 2'd1,
    ST_ERROR  = 2'd2
  } disp_st_e;

  logic [PRE_W-1:0]      r_presc;
  logic [DIG_W-1:0]      r_digit;
  logic [FRM_W-1:0]      r_frame;
  logic [PAGE_W-1:0]     r_page;
  logic [BLK_W-1:0]      r_blink_cnt;
  logic                  r_blink_odd;
  logic [DATA_WIDTH-1:0] r_snap_pc;
  logic [3:0]            r_snap_irq;
  disp_st_e              r_snap_st;

  disp_st_e              w_new_st;
  logic                  w_tick;
  logic                  w_frame_end;
  logic [NIB_W-1:0]      w_nib_idx;
  logic [PAD_W-1:0]      w_pc_pad;
  logic [3:0]            w_nibble;
  logic [4:0]            w_digit_ext;
  logic [7:0]            w_seg;

  function automatic logic [7:0] hex_pat(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0: p = 8'hFC;  4'h1: p = 8'h60;  4'h2: p = 8'hDA;  4'h3: p = 8'hF2;
      4'h4: p = 8'h66;  4'h5: p = 8'hB6;  4'h6: p = 8'hBE;  4'h7: p = 8'hE0;
      4'h8: p = 8'hFE;  4'h9: p = 8'hF6;  4'hA: p = 8'hEE;  4'hB: p = 8'h3E;
      4'hC: p = 8'h9C;  4'hD: p = 8'h7A;  4'hE: p = 8'h9E;  default: p = 8'h8E;
    endcase
    return p;
  endfunction

  always_comb begin
    w_new_st = ST_ERROR;
    if (nstate_i == 3'd1) begin
      w_new_st = ST_NORMAL;
    end else if (nstate_i == 3'd2) begin
      w_new_st = ST_HALT;
    end
  end

  assign w_tick      = (r_presc == PRE_W'(SCAN_DIV - 1));
  assign w_frame_end = w_tick && (r_digit == DIG_W'(NUM_DIGITS - 1));

  // Prescaler and digit scan index
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_presc <= '0;
      r_digit <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_digit <= (r_digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_digit + DIG_W'(1);
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // Frame-boundary snapshot, page sequencing and blink phase
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_snap_pc   <= '0;
      r_snap_irq  <= '0;
      r_snap_st   <= ST_ERROR;
      r_frame     <= '0;
      r_page      <= '0;
      r_blink_cnt <= '0;
      r_blink_odd <= 1'b0;
    end else if (w_frame_end) begin
      r_snap_pc  <= pc_i;
      r_snap_irq <= interrupts_i;
      r_snap_st  <= w_new_st;
      if ((w_new_st != r_snap_st) || (w_new_st == ST_ERROR)) begin
        r_frame <= '0;
        r_page  <= '0;
      end else if (r_frame == FRM_W'(PAGE_FRAMES - 1)) begin
        r_frame <= '0;
        r_page  <= (r_page == PAGE_W'(NUM_PAGES - 1)) ? '0 : r_page + PAGE_W'(1);
      end else begin
        r_frame <= r_frame + FRM_W'(1);
      end
      if ((w_new_st != ST_HALT) || (r_snap_st != ST_HALT)) begin
        r_blink_cnt <= '0;
        r_blink_odd <= 1'b0;
      end else if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_odd <= ~r_blink_odd;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
    end
  end

  assign w_nib_idx   = NIB_W'(r_page) * NIB_W'(NUM_DIGITS) + NIB_W'(r_digit);
  assign w_pc_pad    = PAD_W'(r_snap_pc);
  assign w_nibble    = 4'(w_pc_pad >> {w_nib_idx, 2'b00});
  assign w_digit_ext = 5'(r_digit);

  // Pattern for the digit about to be shown
  always_comb begin
    w_seg = 8'hFF;
    if (r_snap_st == ST_ERROR) begin
      if ((w_digit_ext < 5'd4) && r_snap_irq[w_digit_ext[1:0]]) begin
        w_seg = 8'h6D;
      end
    end else if (!((r_snap_st == ST_HALT) && r_blink_odd)) begin
      if (w_nib_idx < NIB_W'(NUM_NIBS)) begin
        w_seg = ~hex_pat(w_nibble);
      end
`ifdef SEG_PAGE_DP_EN
      if (32'(r_digit) == 32'(r_page)) begin
        w_seg[0] = 1'b0;
      end
`else
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_o <= 8'hFF;
      an_o  <= '1;
    end else if (w_tick) begin
      seg_o <= w_seg;
      an_o  <= ~(NUM_DIGITS'(1) << r_digit);
    end
  end

  assign page_o = r_page;

endmodule

// File: tb/tb_seg_display_mux.sv
// Randomized bench for seg_display_mux against a frame-level reference model.
module tb_seg_display_mux;

  localparam int unsigned DW = 32;
  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned PF = 2;
  localparam int unsigned BF = 1;
  localparam int unsigned NP = 2;
  localparam int unsigned FR = ND * SD;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] pc;
  logic [2:0]    nst;
  logic [3:0]    irq;
  logic [7:0]    seg;
  logic [ND-1:0] an;
  logic [0:0]    page;

  seg_display_mux #(
    .DATA_WIDTH  (DW),
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .PAGE_FRAMES (PF),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pc_i        (pc),
    .nstate_i    (nst),
    .interrupts_i(irq),
    .seg_o       (seg),
    .an_o        (an),
    .page_o      (page)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] hex_lut [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                              8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  int n_total;
  int n_bad;
  int cyc;
  bit in_reset;
  bit dir_on;

  // Model: one snapshot per frame; class 0=NORMAL 1=HALT 2=ERROR, m_since = frames since class entry
  int            m_cls;
  int            m_since;
  logic [31:0]   m_pc;
  logic [3:0]    m_irq;
  logic [7:0]    m_seg;
  logic [ND-1:0] m_an;

  int         d_cyc [6] = '{20, 24, 28, 32, 52, 64};
  logic [7:0] d_seg [6] = '{8'h85, 8'h63, 8'hC1, 8'h11, 8'h99, 8'h9F};
  logic [3:0] d_an  [6] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b0111};
  int         d_dig [6] = '{0, 1, 2, 3, 0, 3};
  int         d_pg  [6] = '{0, 0, 0, 0, 1, 1};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    end
  endtask

  function automatic int cls_of(input logic [2:0] s);
    return (s == 3'd1) ? 0 : (s == 3'd2) ? 1 : 2;
  endfunction

  function automatic int page_of();
    return (m_cls == 2) ? 0 : (m_since / int'(PF)) % int'(NP);
  endfunction

  function automatic logic [7:0] model_seg(input int d);
    int         pg;
    int         n;
    logic [3:0] nib;
    logic [7:0] v;
    if (m_cls == 2) return ((d < 4) && m_irq[d]) ? 8'h6D : 8'hFF;
    if ((m_cls == 1) && (((m_since / int'(BF)) % 2) == 1)) return 8'hFF;
    pg = page_of();
    n  = pg * int'(ND) + d;
    v  = 8'hFF;
    if (n < int'(DW / 4)) begin
      nib = 4'((m_pc >> (4 * n)) & 32'hF);
      v   = ~hex_lut[nib];
    end
`ifdef SEG_PAGE_DP_EN
    if (d == pg) v[0] = 1'b0;
`else
`endif
    return v;
  endfunction

  task automatic reset_model();
    m_cls   = 2;
    m_since = 0;
    m_pc    = '0;
    m_irq   = '0;
    m_seg   = 8'hFF;
    m_an    = '1;
    cyc     = 0;
  endtask

  task automatic step();
    int s;
    int d;
    int nc;
    logic [7:0] exp_d;
    @(posedge clk);
    #1;
    if (!in_reset) begin
      cyc++;
      if ((cyc % int'(SD)) == 0) begin
        s     = cyc / int'(SD) - 1;
        d     = s % int'(ND);
        m_seg = model_seg(d);
        m_an  = ~(4'b0001 << d);
        if (d == int'(ND) - 1) begin
          nc      = cls_of(nst);
          m_since = (nc == m_cls) ? m_since + 1 : 0;
          m_cls   = nc;
          m_pc    = pc;
          m_irq   = irq;
        end
      end
    end
    check_val("seg", 32'(seg), 32'(m_seg));
    check_val("an", 32'(an), 32'(m_an));
    check_val("page", 32'(page), 32'(page_of()));
    if (dir_on) begin
      for (int i = 0; i < 6; i++) begin
        if (cyc == d_cyc[i]) begin
          exp_d = d_seg[i];
`ifdef SEG_PAGE_DP_EN
          if (d_dig[i] == d_pg[i]) exp_d[0] = 1'b0;
`else
`endif
          check_val("dir_seg", 32'(seg), 32'(exp_d));
          check_val("dir_an", 32'(an), 32'(d_an[i]));
          check_val("dir_page", 32'(page), 32'(d_pg[i]));
        end
      end
    end
  endtask

  // Async assertion between edges, checked before the next edge
  task automatic mid_reset(input int hold);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_async_seg", 32'(seg), 32'h0000_00FF);
    check_val("rst_async_an", 32'(an), 32'h0000_000F);
    check_val("rst_async_page", 32'(page), 32'h0);
    reset_model();
    in_reset = 1'b1;
    repeat (hold) step();
    rst_n    = 1'b1;
    in_reset = 1'b0;
    cyc      = 0;
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    dir_on   = 1'b0;
    in_reset = 1'b1;
    rst_n    = 1'b1;
    pc       = 32'h1234_ABCD;
    nst      = 3'd1;
    irq      = 4'd0;
    reset_model();
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n    = 1'b1;
    in_reset = 1'b0;
    cyc      = 0;
    dir_on   = 1'b1;

    // NORMAL paging, then a mid-frame value change
    repeat (4 * FR + 6) step();
    pc = 32'hCAFE_5678;
    repeat (2 * FR + 10) step();
    dir_on = 1'b0;

    nst = 3'd2;
    repeat (6 * FR) step();

    nst = 3'd3;
    irq = 4'b0010;
    repeat (3 * FR) step();

    nst = 3'd1;
    pc  = 32'h0F1E_2D3C;
    repeat (2 * FR + 5) step();
    mid_reset(3);
    repeat (SD - 1) step();
    check_val("post_rst_idle_an", 32'(an), 32'h0000_000F);
    step();
    check_val("post_rst_digit0_an", 32'(an), 32'h0000_000E);

    for (int it = 0; it < 40; it++) begin
      int r;
      int len;
      r   = int'($urandom_range(0, 9));
      nst = (r < 4) ? 3'd1 : (r < 7) ? 3'd2 : 3'($urandom_range(0, 7));
      irq = 4'($urandom);
      pc  = $urandom;
      len = int'($urandom_range(4, 80));
      repeat (len / 2) step();
      if ($urandom_range(0, 1) == 1) pc = $urandom;
      repeat (len - len / 2) step();
      if (it == 20) mid_reset(2);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk_i and rst_ni.
REQ-002 Parameter DATA_WIDTH, default 64: width of the displayed value pc_i.
REQ-003 Parameter NUM_DIGITS, default 8 (legal 1..16): number of physical digits scanned.
REQ-004 Parameter SCAN_DIV, default 1000 (>=2): clk cycles per digit slot.
REQ-005 Parameter PAGE_FRAMES, default 256 (>=1): full scan frames per page.
REQ-006 Parameter BLINK_FRAMES, default 128 (>=1): frames per blink half-period.
REQ-007 clk_i  in  1  clock.
REQ-008 rst_ni  in  1  asynchronous active-low reset.
REQ-009 pc_i  in  DATA_WIDTH  value shown in hex.
REQ-010 nstate_i  in  3  core state; 1=NORMAL, 2=HALT, other values=ERROR.
REQ-011 interrupts_i  in  4  anomaly flags; bit0=FetchError, bit1=DecodeError.
REQ-012 seg_o  out  8  active-low segments, bit7=a .. bit1=g, bit0=dp.
REQ-013 an_o  out  NUM_DIGITS  active-low one-hot digit enable.
REQ-014 page_o  out  max(1,$clog2(NUM_PAGES))  currently displayed page index.

Function
REQ-015 NUM_PAGES SHALL be ceil(DATA_WIDTH/(4*NUM_DIGITS)); page p, digit k SHALL show nibble index p*NUM_DIGITS+k; nibbles at or beyond DATA_WIDTH/4 SHALL show blank.
REQ-016 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; each wrap (scan tick) SHALL advance the digit index 0..NUM_DIGITS-1 with wrap to 0.
REQ-017 seg_o and an_o SHALL be registered; they SHALL change exactly 1 cycle after each scan tick, and an_o SHALL have exactly one bit low outside reset.
REQ-018 A frame SHALL end when the digit index wraps to 0; at that wrap, pc_i, nstate_i and interrupts_i SHALL be snapshotted; all digits of a frame SHALL use one snapshot (no tearing).
REQ-019 Page counter SHALL advance every PAGE_FRAMES frames and wrap after NUM_PAGES-1; if NUM_PAGES==1 it SHALL stay 0.
REQ-020 Hex encodings (pre-inversion, a..g,dp) SHALL be 0:FC 1:60 2:DA 3:F2 4:66 5:B6 6:BE 7:E0 8:FE 9:F6 A:EE b:3E C:9C d:7A E:9E F:8E; seg_o SHALL be the bitwise inverse; blank SHALL be 8'hFF.
REQ-021 NORMAL: digits SHALL show hex of the snapshotted value on the current page.
REQ-022 HALT: as NORMAL, but seg_o SHALL be 8'hFF during odd blink half-periods; the blink counter SHALL count frames, restarting at the visible phase on each snapshot entering HALT.
REQ-023 ERROR: page SHALL be forced to 0 and held; digit k<4 SHALL show 8'h6D if snapshot interrupts_i[k]=1, else 8'hFF; digits k>=4 SHALL show 8'hFF.
REQ-024 A snapshotted state change SHALL reset the page counter and the page frame counter to 0.
REQ-025 Counter widths SHALL be $clog2 of their moduli, and no counter SHALL exceed its modulus.

Reset
REQ-026 While rst_ni=0: seg_o=8'hFF, an_o=all ones, page_o=0, prescaler, digit index, frame, page and blink counters=0, snapshot=0 with state ERROR and no flags.
REQ-027 Reset assertion mid-frame SHALL take effect immediately (asynchronous); after release the first scan tick SHALL occur SCAN_DIV cycles later and select digit 0.

Configuration
REQ-028 With macro SEG_PAGE_DP_EN defined, dp (bit0) SHALL be driven low on the digit whose index equals page_o in NORMAL and HALT (subject to blink blanking); without it, bit0 SHALL always be 1.

Verification
REQ-029 NUM_DIGITS=4, DATA_WIDTH=32, SCAN_DIV=4, PAGE_FRAMES=2; NORMAL, pc_i=32'h1234ABCD -> page 0 shows D,C,B,A (seg 8'h85,8'h63,8'hC1,8'h11) on an_o 4'b1110..4'b0111 each 4 cycles; page 1 after 2 frames shows 4,3,2,1.
REQ-030 Change pc_i mid-frame -> remaining digits of that frame show the old value; the new value appears from the next digit 0.
REQ-031 HALT with BLINK_FRAMES=1 -> alternate frames show pc_i digits, then all 8'hFF.
REQ-032 nstate_i=3, interrupts_i=4'b0010 -> digit1=8'h6D, digits 0,2,3=8'hFF, page_o=0 throughout.
REQ-033 Assert rst_ni low mid-frame -> seg_o=8'hFF and an_o=4'b1111 the same cycle; after release digit 0 is selected on cycle SCAN_DIV+1.
REQ-034 SEG_PAGE_DP_EN defined, page 1 -> digit1 seg_o bit0=0, others bit0=1; undefined -> bit0=1 always.
